inst_fetch_unit: RTL

//   Instruction fetch stage directly upstream of the CPU controller (mCpu_ctrl).
//   - Issues pipelined word reads to instruction memory over an Avalon-style read master.
//   - Buffers returned words with their PC in a small in-order FIFO.
//   - Presents the head entry to the controller as inst/inst_valid/empty.
//   - Supports branch redirect: flushes the FIFO and discards in-flight read data.

---
 rtl/inst_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: pipelined Avalon-style word reads feeding a small in-order FIFO
// of {pc, word} entries, with branch redirect that flushes the FIFO and drops in-flight beats.
module inst_fetch_unit #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] PC_STEP    = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pc_load,
  input  logic [31:0] i_pc_target,
  input  logic        i_inst_complete,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_inst_valid,
  output logic        o_empty,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_read,
  input  logic        i_mem_waitrequest,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_readdatavalid
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  typedef logic [CntW-1:0]       cnt_t;
  typedef logic [CntW:0]         sum_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef enum logic {StRun, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  cnt_t        occ_q, occ_d;
  cnt_t        outs_q, outs_d;
  cnt_t        drop_q, drop_d;
  ptr_t        fifo_wr_q, fifo_rd_q;
  ptr_t        pcq_wr_q, pcq_rd_q;

  logic [31:0] fifo_inst_q [Depth];
  logic [31:0] fifo_pc_q   [Depth];
  logic [31:0] pcq_q       [Depth];

  logic accept, stalled, dropping, push, pop;
  sum_t avail;

  always_comb begin
    accept   = mem_read_q & ~i_mem_waitrequest;
    stalled  = mem_read_q & i_mem_waitrequest;
    dropping = i_mem_readdatavalid & (drop_q != '0);
    // Redirect wins over a same-cycle response and pop.
    push     = i_mem_readdatavalid & (drop_q == '0) & ~i_pc_load;
    pop      = i_inst_complete & (occ_q != '0) & ~i_pc_load;

    outs_d = outs_q + cnt_t'(accept) - cnt_t'(i_mem_readdatavalid);
    occ_d  = i_pc_load ? '0 : occ_q + cnt_t'(push) - cnt_t'(pop);

    // A request held across a redirect is only counted as in flight once accepted.
    if (i_pc_load) begin
      drop_d = outs_d;
    end else begin
      drop_d = drop_q - cnt_t'(dropping) + cnt_t'((state_q == StHold) & accept);
    end

    state_d = state_q;
    if (i_pc_load && stalled) begin
      state_d = StHold;
    end else if (state_q == StHold && accept) begin
      state_d = StRun;
    end

    fetch_pc_d = fetch_pc_q;
    if (i_pc_load) begin
      fetch_pc_d = i_pc_target;
    end else if (accept && state_q == StRun) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    // Credit covers buffered entries plus beats that will still be kept.
    avail      = sum_t'(occ_d) + sum_t'(outs_d) - sum_t'(drop_d);
    mem_read_d = stalled | ((avail < sum_t'(Depth)) & (outs_d < cnt_t'(Depth)));
    mem_addr_d = stalled ? mem_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      mem_read_q <= 1'b0;
      mem_addr_q <= RESET_PC;
      occ_q      <= '0;
      outs_q     <= '0;
      drop_q     <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      occ_q      <= occ_d;
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      pcq_wr_q   <= pcq_wr_q + ptr_t'(accept);
      pcq_rd_q   <= pcq_rd_q + ptr_t'(i_mem_readdatavalid);
      if (i_pc_load) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        fifo_wr_q <= fifo_wr_q + ptr_t'(push);
        fifo_rd_q <= fifo_rd_q + ptr_t'(pop);
      end
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      pcq_q[pcq_wr_q] <= mem_addr_q;
    end
    if (!rst && push) begin
      fifo_inst_q[fifo_wr_q] <= i_mem_readdata;
      fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
      assert (occ_q != cnt_t'(Depth));
    end
  end

  always_comb begin
    o_empty      = (occ_q == '0);
    o_inst_valid = ~o_empty;
    o_inst       = o_inst_valid ? fifo_inst_q[fifo_rd_q] : 32'h0;
    o_pc         = o_inst_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
    o_mem_read   = mem_read_q;
    o_mem_addr   = mem_addr_q;
  end

endmodule
